// File: rtl/pconv_c1_ctrl_pkg.sv
// Shared definitions for the first-layer pointwise conv sequencer.
//  - FSM state encodings (3-bit) and the state enum built on them.
//  - Helpers for the per-group pixel count and the counter widths.
package pconv_c1_ctrl_pkg;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_PARAM  = 3'd1;
    localparam logic [2:0] ENC_STREAM = 3'd2;
    localparam logic [2:0] ENC_DRAIN  = 3'd3;
    localparam logic [2:0] ENC_FIN    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_PARAM  = ENC_PARAM,
        ST_STREAM = ENC_STREAM,
        ST_DRAIN  = ENC_DRAIN,
        ST_FIN    = ENC_FIN
    } state_t;

    // Pixels per group for a square feature map.
    function automatic int pix_count(input int side);
        return side * side;
    endfunction

    // Bits needed to hold every value 0..maxval inclusive (at least 1).
    function automatic int cnt_width(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/pconv_c1_ctrl_addr_gen.sv
// Counter bank for the conv sequencer.
//  Holds the pixel fetch counter, the output counter and the group index,
//  and forms the result write address grp*PIX + ocnt in AW bits.
// Ports:
//  clk, rst_n           clock, synchronous active-low reset
//  pix_inc / pix_clr    advance / clear the fetch counter (clear wins)
//  ocnt_inc / ocnt_clr  advance / clear the output counter (clear wins)
//  grp_inc / grp_clr    advance / clear the group index (clear wins)
//  pix, ocnt, grp       current counter values
//  out_addr             result RAM address for the current output
module pconv_addr_gen
    import pconv_c1_ctrl_pkg::*;
#(
    parameter int PIX        = 36,
    parameter int OUT_GROUPS = 2,
    parameter int AW         = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              pix_inc,
    input  logic                              pix_clr,
    input  logic                              ocnt_inc,
    input  logic                              ocnt_clr,
    input  logic                              grp_inc,
    input  logic                              grp_clr,
    output logic [cnt_width(PIX)-1:0]         pix,
    output logic [cnt_width(PIX)-1:0]         ocnt,
    output logic [cnt_width(OUT_GROUPS)-1:0]  grp,
    output logic [AW-1:0]                     out_addr
);

    localparam int CW = cnt_width(PIX);
    localparam int GW = cnt_width(OUT_GROUPS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix  <= '0;
            ocnt <= '0;
            grp  <= '0;
        end else begin
            if (pix_clr)
                pix <= '0;
            else if (pix_inc)
                pix <= pix + CW'(1);

            if (ocnt_clr)
                ocnt <= '0;
            else if (ocnt_inc)
                ocnt <= ocnt + CW'(1);

            if (grp_clr)
                grp <= '0;
            else if (grp_inc)
                grp <= grp + GW'(1);
        end
    end

    // Base-plus-offset, deliberately computed and wrapped in AW bits.
    assign out_addr = (AW'(grp) * AW'(PIX)) + AW'(ocnt);

endmodule

// File: rtl/pconv_c1_ctrl.sv
// Sequencer for the first-layer pointwise conv array.
//  For each output-channel group: fetch the group's parameter word, wait for
//  it to settle at the array, stream every pixel of the feature map into the
//  array, then wait until all of that group's outputs have been written.
//  A one-cycle done pulse follows the last group.
// Ports:
//  clk, rst_n       clock, synchronous active-low reset
//  start            one-cycle start request (honoured only when idle)
//  busy, done       job in progress / job complete pulse
//  fmap_rd_en/addr  feature RAM read port (1-cycle read latency)
//  fmap_rdata       feature RAM read data
//  param_rd_en/addr param ROM read port, one read per group
//  conv_input_vld/din  pixel stream into the array
//  conv_dout_vld    array output valid (all lanes)
//  out_wr_en/addr   result RAM write strobe and address
module pconv_c1_ctrl
    import pconv_c1_ctrl_pkg::*;
#(
    parameter int N          = 16,
    parameter int INPUT_SIZE = 6,
    parameter int OUT_GROUPS = 2,
    parameter int PARAM_LAT  = 2,
    parameter int AW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fmap_rd_en,
    output logic [AW-1:0] fmap_addr,
    input  logic [N-1:0]  fmap_rdata,
    output logic          param_rd_en,
    output logic [7:0]    param_addr,
    output logic          conv_input_vld,
    output logic [N-1:0]  conv_input_din,
    input  logic          conv_dout_vld,
    output logic          out_wr_en,
    output logic [AW-1:0] out_addr
);

    localparam int PIX = pix_count(INPUT_SIZE);
    localparam int CW  = cnt_width(PIX);
    localparam int GW  = cnt_width(OUT_GROUPS);
    localparam int PW  = cnt_width(PARAM_LAT);

    localparam logic [CW-1:0] PIX_ALL  = CW'(PIX);
    localparam logic [CW-1:0] PIX_LAST = CW'(PIX - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(OUT_GROUPS - 1);
    localparam logic [PW-1:0] PLAT     = PW'(PARAM_LAT);

    state_t          state;
    logic [PW-1:0]   pcnt;

    logic [CW-1:0]   pix;
    logic [CW-1:0]   ocnt;
    logic [GW-1:0]   grp;

    logic            accept;
    logic            count_en;
    logic            pix_last;
    logic            grp_last;
    logic            outputs_done;
    logic            drain_exit;

    assign accept   = (state == ST_IDLE) && start;
    assign count_en = (state == ST_STREAM) || (state == ST_DRAIN);
    assign pix_last = (pix == PIX_LAST);
    assign grp_last = (grp == GRP_LAST);

    // Outputs may start while pixels are still streaming, so counting runs
    // in both STREAM and DRAIN; anything the array signals elsewhere is dropped.
    assign out_wr_en = conv_dout_vld && count_en;

    // The write that brings ocnt to PIX ends the group in the same cycle.
    assign outputs_done = (ocnt == PIX_ALL) || (out_wr_en && (ocnt == PIX_LAST));
    assign drain_exit   = (state == ST_DRAIN) && outputs_done;

    pconv_addr_gen #(
        .PIX        (PIX),
        .OUT_GROUPS (OUT_GROUPS),
        .AW         (AW)
    ) u_addr (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_inc  ((state == ST_STREAM) && !pix_last),
        .pix_clr  (accept || ((state == ST_STREAM) && pix_last)),
        .ocnt_inc (out_wr_en),
        .ocnt_clr (accept || drain_exit),
        .grp_inc  (drain_exit && !grp_last),
        .grp_clr  (accept || (drain_exit && grp_last)),
        .pix      (pix),
        .ocnt     (ocnt),
        .grp      (grp),
        .out_addr (out_addr)
    );

    assign fmap_addr = AW'(pix);

    // The feature RAM output register already aligns read data with the
    // delayed valid, so the data is forwarded and only gated by valid.
    assign conv_input_din = conv_input_vld ? fmap_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            pcnt           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            param_rd_en    <= 1'b0;
            param_addr     <= '0;
            fmap_rd_en     <= 1'b0;
            conv_input_vld <= 1'b0;
        end else begin
            done           <= 1'b0;
            param_rd_en    <= 1'b0;
            conv_input_vld <= fmap_rd_en;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_PARAM;
                        busy        <= 1'b1;
                        param_rd_en <= 1'b1;
                        param_addr  <= '0;
                        pcnt        <= '0;
                    end
                end

                // Read cycle plus PARAM_LAT settle cycles before the first fetch.
                ST_PARAM: begin
                    if (pcnt == PLAT) begin
                        state      <= ST_STREAM;
                        fmap_rd_en <= 1'b1;
                        pcnt       <= '0;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end

                ST_STREAM: begin
                    if (pix_last) begin
                        state      <= ST_DRAIN;
                        fmap_rd_en <= 1'b0;
                    end
                end

                // Next group's parameters are only read once this group is fully
                // written, so weights never change under an in-flight pixel.
                ST_DRAIN: begin
                    if (outputs_done) begin
                        if (grp_last) begin
                            state <= ST_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state       <= ST_PARAM;
                            param_rd_en <= 1'b1;
                            param_addr  <= 8'(grp) + 8'd1;
                            pcnt        <= '0;
                        end
                    end
                end

                ST_FIN: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pconv_c1_ctrl.sv
module tb_pconv_c1_ctrl;
    import pconv_c1_ctrl_pkg::*;

    localparam int N          = 16;
    localparam int INPUT_SIZE = 6;
    localparam int OUT_GROUPS = 2;
    localparam int PARAM_LAT  = 2;
    localparam int AW         = 16;
    localparam int PIX        = INPUT_SIZE * INPUT_SIZE;
    localparam int ARR_LAT    = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          fmap_rd_en;
    logic [AW-1:0] fmap_addr;
    logic [N-1:0]  fmap_rdata;
    logic          param_rd_en;
    logic [7:0]    param_addr;
    logic          conv_input_vld;
    logic [N-1:0]  conv_input_din;
    logic          conv_dout_vld;
    logic          out_wr_en;
    logic [AW-1:0] out_addr;

    logic          spur_vld;
    logic [ARR_LAT-1:0] arr_sr;

    int tests = 0;
    int fails = 0;

    int q_param[$];
    int q_fmap[$];
    int q_din[$];
    int q_out[$];

    int cyc;
    int param_cyc;
    bit await_first;
    bit prev_rd_en;
    int wr_cnt;
    int grp_seen;
    int done_cnt;

    pconv_c1_ctrl #(
        .N          (N),
        .INPUT_SIZE (INPUT_SIZE),
        .OUT_GROUPS (OUT_GROUPS),
        .PARAM_LAT  (PARAM_LAT),
        .AW         (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .fmap_rd_en     (fmap_rd_en),
        .fmap_addr      (fmap_addr),
        .fmap_rdata     (fmap_rdata),
        .param_rd_en    (param_rd_en),
        .param_addr     (param_addr),
        .conv_input_vld (conv_input_vld),
        .conv_input_din (conv_input_din),
        .conv_dout_vld  (conv_dout_vld),
        .out_wr_en      (out_wr_en),
        .out_addr       (out_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Feature RAM: 1-cycle read latency, content = address + 1.
    initial fmap_rdata = '0;
    always @(posedge clk)
        if (fmap_rd_en) fmap_rdata <= fmap_addr[N-1:0] + 16'd1;

    // Array: output valid is the input valid delayed ARR_LAT cycles.
    initial arr_sr = '0;
    always @(posedge clk) arr_sr <= {arr_sr[ARR_LAT-2:0], conv_input_vld};
    assign conv_dout_vld = arr_sr[ARR_LAT-1] | spur_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_job();
        for (int g = 0; g < OUT_GROUPS; g++) begin
            q_param.push_back(g);
            for (int p = 0; p < PIX; p++) begin
                q_fmap.push_back(p);
                q_din.push_back(p + 1);
                q_out.push_back(g * PIX + p);
            end
        end
    endtask

    task automatic flush_queues();
        q_param.delete();
        q_fmap.delete();
        q_din.delete();
        q_out.delete();
    endtask

    // Scoreboard: pops one expectation per DUT event, sampled on the falling edge.
    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_rd_en  = 1'b0;
                await_first = 1'b0;
                wr_cnt      = 0;
                grp_seen    = 0;
                done_cnt    = 0;
            end else begin
                if (start && !busy && !done) begin
                    wr_cnt   = 0;
                    grp_seen = 0;
                    done_cnt = 0;
                end
                if (param_rd_en) begin
                    if (q_param.size() == 0) chk("unexpected_param_rd", 1, 0);
                    else chk("param_addr", 32'(param_addr), q_param.pop_front());
                    chk("param_after_prev_group_writes", wr_cnt, grp_seen * PIX);
                    grp_seen++;
                    param_cyc   = cyc;
                    await_first = 1'b1;
                end
                if (fmap_rd_en) begin
                    if (await_first) begin
                        chk("param_to_first_fetch", cyc - param_cyc, PARAM_LAT + 1);
                        await_first = 1'b0;
                    end
                    if (q_fmap.size() == 0) chk("unexpected_fmap_rd", 1, 0);
                    else chk("fmap_addr", 32'(fmap_addr), q_fmap.pop_front());
                end
                if (conv_input_vld || prev_rd_en)
                    chk("vld_follows_rd_en", 32'(conv_input_vld), 32'(prev_rd_en));
                if (conv_input_vld) begin
                    if (q_din.size() == 0) chk("unexpected_input_vld", 1, 0);
                    else chk("conv_input_din", 32'(conv_input_din), q_din.pop_front());
                end
                if (out_wr_en) begin
                    if (q_out.size() == 0) chk("unexpected_out_wr", 1, 0);
                    else chk("out_addr", 32'(out_addr), q_out.pop_front());
                    wr_cnt++;
                end
                if (done) begin
                    done_cnt++;
                    chk("busy_low_at_done", 32'(busy), 0);
                    chk("writes_before_done", wr_cnt, OUT_GROUPS * PIX);
                end
                prev_rd_en = fmap_rd_en;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        chk("done_seen", 32'(got), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_fmap_rd_en"}, 32'(fmap_rd_en), 0);
        chk({tag, "_fmap_addr"}, 32'(fmap_addr), 0);
        chk({tag, "_param_rd_en"}, 32'(param_rd_en), 0);
        chk({tag, "_param_addr"}, 32'(param_addr), 0);
        chk({tag, "_input_vld"}, 32'(conv_input_vld), 0);
        chk({tag, "_input_din"}, 32'(conv_input_din), 0);
        chk({tag, "_out_wr_en"}, 32'(out_wr_en), 0);
        chk({tag, "_out_addr"}, 32'(out_addr), 0);
        chk({tag, "_state"}, 32'(dut.state), 32'(ST_IDLE));
    endtask

    task automatic finish_job_checks(input string tag);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_q_fmap_empty"}, q_fmap.size(), 0);
        chk({tag, "_q_din_empty"}, q_din.size(), 0);
        chk({tag, "_q_out_empty"}, q_out.size(), 0);
        chk({tag, "_q_param_empty"}, q_param.size(), 0);
    endtask

    initial begin
        bit got;
        rst_n    = 1'b0;
        start    = 1'b0;
        spur_vld = 1'b0;
        cyc      = 0;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Spurious array valid while idle
        spur_vld = 1'b1;
        #1;
        chk("idle_spur_no_write", 32'(out_wr_en), 0);
        @(posedge clk); #1;
        spur_vld = 1'b0;
        chk("idle_spur_ocnt", 32'(dut.u_addr.ocnt), 0);

        // Full job: two groups, streaming, draining, param timing
        push_job();
        pulse_start();
        chk("busy_after_start", 32'(busy), 1);
        wait_done(got);
        finish_job_checks("job1");

        // Start pulses in PARAM, STREAM and FIN are ignored
        push_job();
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (param_rd_en) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("job2_param_seen", 32'(got), 1);
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (fmap_rd_en && fmap_addr == 20) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("job2_stream_seen", 32'(got), 1);
        pulse_start();
        wait_done(got);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("job2_no_restart_busy", 32'(busy), 0);
        chk("job2_no_restart_state", 32'(dut.state), 32'(ST_IDLE));
        chk("job2_done_once", done_cnt, 1);
        chk("job2_q_out_empty", q_out.size(), 0);
        chk("job2_q_fmap_empty", q_fmap.size(), 0);

        // Reset in the middle of group 1 streaming
        push_job();
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            if (grp_seen == 2 && fmap_rd_en && fmap_addr == 10) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("job3_reached_grp1", 32'(got), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        flush_queues();
        repeat (10) @(posedge clk);
        #1;
        chk("midreset_no_done", done_cnt, 0);
        chk("midreset_still_idle", 32'(busy), 0);

        // Rerun after the abort behaves like a fresh job
        push_job();
        pulse_start();
        wait_done(got);
        finish_job_checks("job4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
